// File: rtl/ternary_matmul_array.sv
// Ternary-weight x int8 accumulator grid. Operands stream in SLICES beats per group.
// A flush snapshots the grid into a double-buffered queue that drains with shift/ReLU/saturation.
module ternary_matmul_array #(
    parameter int WPB    = 4,
    parameter int SLICES = 2,
    parameter int ACC_W  = 17,
    parameter int SH_W   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [2*WPB-1:0]    in_weights,
    input  logic [7:0]          in_act,
    input  logic                in_flush,
    output logic                flush_ready,
    input  logic [SH_W-1:0]     cfg_shift,
    input  logic                cfg_relu,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy
);

    localparam int COLS  = SLICES;
    localparam int ROWS  = WPB * SLICES;
    localparam int N_ENT = ROWS * COLS;
    localparam int CNT_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int PTR_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;

    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(N_ENT - 1);

    // Signed product of a ternary weight (00=0, 01=+1, 1x=-1) and an int8 activation.
    function automatic logic signed [ACC_W-1:0] f_term(
        input logic [1:0]        w,
        input logic signed [7:0] a
    );
        logic signed [ACC_W-1:0] v_ext;
        v_ext = {{(ACC_W-8){a[7]}}, a};
        case (w)
            2'b00:   f_term = '0;
            2'b01:   f_term = v_ext;
            default: f_term = -v_ext;
        endcase
    endfunction

    // Load-side staging
    logic [CNT_W-1:0]        r_slice_cnt;
    logic [1:0]              r_wgt_next   [ROWS];
    logic signed [7:0]       r_act_next   [SLICES];
    logic [1:0]              w_wgt_merged [ROWS];
    logic signed [7:0]       w_act_merged [SLICES];

    // Compute-side operands
    logic [1:0]              r_wgt_cur    [ROWS];
    logic signed [7:0]       r_act_cur    [SLICES];
    logic [CNT_W-1:0]        r_col_cnt;
    logic                    r_compute_active;

    // Accumulators and output queue
    logic signed [ACC_W-1:0] r_acc        [ROWS][COLS];
    logic signed [ACC_W-1:0] r_queue      [N_ENT];
    logic [PTR_W-1:0]        r_ptr;
    logic                    r_out_valid;

    logic                    w_commit;
    logic                    w_flush_accept;
    logic                    w_xfer;
    logic                    w_busy;
    logic signed [7:0]       w_col_act;
    logic signed [ACC_W-1:0] w_term       [ROWS];

    logic signed [ACC_W-1:0] w_entry;
    logic signed [ACC_W-1:0] w_shifted;
    logic signed [ACC_W-1:0] w_clip;
    logic                    w_fits;
    logic [7:0]              w_sat;

    assign w_busy         = (r_slice_cnt != '0) | r_compute_active;
    assign w_commit       = in_valid & (r_slice_cnt == LAST_SLICE);
    assign w_flush_accept = in_flush & flush_ready;
    assign w_xfer         = r_out_valid & out_ready;

    assign busy        = w_busy;
    assign flush_ready = ~w_busy & ~r_out_valid;

    // The group image as it stands after the current beat lands; the last beat of a
    // group must reach the compute operands on the same edge it is loaded.
    // NOTE: every always_comb output gets a default before any conditional override,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        for (int s = 0; s < SLICES; s++) begin
            w_act_merged[s] = r_act_next[s];
            for (int k = 0; k < WPB; k++) begin
                w_wgt_merged[s*WPB + k] = r_wgt_next[s*WPB + k];
            end
            if (r_slice_cnt == CNT_W'(s)) begin
                w_act_merged[s] = in_act;
                for (int k = 0; k < WPB; k++) begin
                    w_wgt_merged[s*WPB + k] = in_weights[2*k +: 2];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slice_cnt <= '0;
            for (int r = 0; r < ROWS; r++)   r_wgt_next[r] <= '0;
            for (int s = 0; s < SLICES; s++) r_act_next[s] <= '0;
        end else if (in_valid) begin
            for (int r = 0; r < ROWS; r++)   r_wgt_next[r] <= w_wgt_merged[r];
            for (int s = 0; s < SLICES; s++) r_act_next[s] <= w_act_merged[s];
            r_slice_cnt <= (r_slice_cnt == LAST_SLICE) ? '0 : r_slice_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_cnt        <= '0;
            r_compute_active <= 1'b0;
            for (int r = 0; r < ROWS; r++)   r_wgt_cur[r] <= '0;
            for (int s = 0; s < SLICES; s++) r_act_cur[s] <= '0;
        end else if (w_commit) begin
            r_col_cnt        <= '0;
            r_compute_active <= 1'b1;
            for (int r = 0; r < ROWS; r++)   r_wgt_cur[r] <= w_wgt_merged[r];
            for (int s = 0; s < SLICES; s++) r_act_cur[s] <= w_act_merged[s];
        end else if (r_compute_active) begin
            if (r_col_cnt == LAST_SLICE) begin
                r_col_cnt        <= '0;
                r_compute_active <= 1'b0;
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    assign w_col_act = r_act_cur[r_col_cnt];

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            w_term[r] = f_term(r_wgt_cur[r], w_col_act);
        end
    end

    // A commit on the last compute edge swaps operands only after that edge, so the
    // old group's final column still lands here. Overflow wraps by design.
    // NOTE: the accumulator and queue arrays are reset like any other register because
    // a flush right after reset must read back zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) r_acc[r][c] <= '0;
        end else if (w_flush_accept) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) r_acc[r][c] <= '0;
        end else if (r_compute_active) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (r_col_cnt == CNT_W'(c)) r_acc[r][c] <= r_acc[r][c] + w_term[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < N_ENT; e++) r_queue[e] <= '0;
        end else if (w_flush_accept) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) r_queue[r*COLS + c] <= r_acc[r][c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_flush_accept) begin
            r_out_valid <= 1'b1;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            if (r_ptr == LAST_PTR) begin
                r_out_valid <= 1'b0;
                r_ptr       <= '0;
            end else begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // Readout: floor shift, optional ReLU, then clamp to int8. The value fits in
    // int8 exactly when all bits from bit 7 upward agree.
    assign w_entry   = r_queue[r_ptr];
    assign w_shifted = w_entry >>> cfg_shift;
    assign w_clip    = (cfg_relu && w_shifted[ACC_W-1]) ? '0 : w_shifted;
    assign w_fits    = (&w_clip[ACC_W-1:7]) | ~(|w_clip[ACC_W-1:7]);
    assign w_sat     = w_fits ? w_clip[7:0] : (w_clip[ACC_W-1] ? 8'h80 : 8'h7F);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? w_sat : 8'h00;
    assign out_last  = r_out_valid & (r_ptr == LAST_PTR);

endmodule

// File: tb/tb_ternary_matmul_array.sv
// Self-checking bench for ternary_matmul_array: table-driven flush vectors plus
// hand-written sequences for backpressure, gapped loads, ignored flushes and reset.
module tb_ternary_matmul_array;

    localparam int WPB   = 4;
    localparam int SLICES = 2;
    localparam int ACC_W = 17;
    localparam int SH_W  = 5;
    localparam int ROWS  = WPB * SLICES;
    localparam int COLS  = SLICES;
    localparam int N_ENT = ROWS * COLS;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic [2*WPB-1:0] in_weights;
    logic [7:0]      in_act;
    logic            in_flush;
    logic            flush_ready;
    logic [SH_W-1:0] cfg_shift;
    logic            cfg_relu;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;

    ternary_matmul_array #(
        .WPB(WPB), .SLICES(SLICES), .ACC_W(ACC_W), .SH_W(SH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_weights(in_weights), .in_act(in_act),
        .in_flush(in_flush), .flush_ready(flush_ready),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] data;
        logic              last;
    } exp_t;

    // One flush scenario: groups of (w0,a0,w1,a1), then zero-weight groups, then a
    // flush with the given readout config. e_rc: r=0 rows 0..3, r=1 rows 4..7; c=column.
    typedef struct {
        logic [7:0] w0;
        int         a0;
        logic [7:0] w1;
        int         a1;
        int         groups;
        int         zeros;
        int         shift;
        bit         relu;
        int         e00;
        int         e01;
        int         e10;
        int         e11;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_xfer = 0;
    int   ready_mode = 0;
    int   m_acc [ROWS][COLS];

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int wdec(input logic [1:0] b);
        if (b == 2'b00) return 0;
        if (b == 2'b01) return 1;
        return -1;
    endfunction

    function automatic int wrap_acc(input int v);
        logic signed [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return int'(t);
    endfunction

    function automatic int exp_out(input int acc, input int sh, input bit relu);
        int r;
        r = acc >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    // Scoreboard pop on every handshake, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_xfer++;
            if (sb.size() == 0) begin
                check("unexpected_output_sb_size", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("out_data", int'($signed(out_data)), int'(e.data));
                check("out_last", int'(out_last), int'(e.last));
            end
        end
    end

    // Consumer: always ready, or the 1,0,0,1 backpressure pattern.
    initial begin
        int rc;
        rc = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rc++;
            if (ready_mode == 0) out_ready = 1'b1;
            else                 out_ready = ((rc % 4) == 0) || ((rc % 4) == 3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) m_acc[i][j] = 0;
    endtask

    task automatic model_group(input logic [7:0] w0, input int a0,
                               input logic [7:0] w1, input int a1);
        for (int i = 0; i < ROWS; i++) begin
            logic [1:0] b;
            int wv;
            b  = (i < WPB) ? w0[2*i +: 2] : w1[2*(i-WPB) +: 2];
            wv = wdec(b);
            m_acc[i][0] = wrap_acc(m_acc[i][0] + wv * a0);
            m_acc[i][1] = wrap_acc(m_acc[i][1] + wv * a1);
        end
    endtask

    task automatic beat(input logic [7:0] w, input int a);
        in_valid   = 1'b1;
        in_weights = w;
        in_act     = 8'(a);
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic group(input logic [7:0] w0, input int a0,
                         input logic [7:0] w1, input int a1);
        beat(w0, a0);
        beat(w1, a1);
        model_group(w0, a0, w1, a1);
    endtask

    task automatic push_model(input int sh, input bit relu);
        exp_t e;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                e.data = 8'(exp_out(m_acc[i][j], sh, relu));
                e.last = ((i*COLS + j) == N_ENT-1);
                sb.push_back(e);
            end
    endtask

    task automatic push_const(input vec_t v);
        exp_t e;
        int   x;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                if (i < WPB) x = (j == 0) ? v.e00 : v.e01;
                else         x = (j == 0) ? v.e10 : v.e11;
                e.data = 8'(x);
                e.last = ((i*COLS + j) == N_ENT-1);
                sb.push_back(e);
            end
    endtask

    task automatic flush(input int sh, input bit relu);
        int k;
        cfg_shift = SH_W'(sh);
        cfg_relu  = relu;
        k = 0;
        while (!flush_ready && k < 50) begin
            tick();
            k++;
        end
        check("flush_ready_before_flush", int'(flush_ready), 1);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        clear_model();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((out_valid || sb.size() != 0) && k < 300) begin
            tick();
            k++;
        end
        check("drain_sb_left", sb.size(), 0);
        check("drain_out_valid", int'(out_valid), 0);
    endtask

    vec_t vecs[9];

    initial begin
        int base;
        int k;

        vecs[0] = '{8'h55,   10, 8'hAA,    3,   1, 0, 0, 1'b0,   10,  3,  -10,   -3};
        vecs[1] = '{8'h55,   10, 8'hAA,    3,   1, 5, 0, 1'b0,   10,  3,  -10,   -3};
        vecs[2] = '{8'h00,    0, 8'h00,    0,   0, 0, 0, 1'b0,    0,  0,    0,    0};
        vecs[3] = '{8'h55,  127, 8'hAA,  127,  20, 0, 0, 1'b0,  127, 127, -128, -128};
        vecs[4] = '{8'h55,  127, 8'hAA,  127,  20, 0, 5, 1'b0,   79,  79,  -80,  -80};
        vecs[5] = '{8'h55,  127, 8'hAA,  127,  20, 0, 5, 1'b1,   79,  79,    0,    0};
        vecs[6] = '{8'h55,  -50, 8'hAA,    7,   3, 0, 1, 1'b0,  -75,  10,   75,  -11};
        vecs[7] = '{8'hFF, -128, 8'hFF, -128, 520, 0, 9, 1'b0, -126, -126, -126, -126};
        vecs[8] = '{8'h55,   -1, 8'hAA,    1,   1, 0, 20, 1'b0,  -1,   0,    0,   -1};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_weights = '0;
        in_act     = '0;
        in_flush   = 1'b0;
        cfg_shift  = '0;
        cfg_relu   = 1'b0;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_last",  int'(out_last), 0);
        check("reset_out_data",  int'(out_data), 0);
        check("reset_busy",      int'(busy), 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_flush_ready", int'(flush_ready), 1);

        // Table-driven flush scenarios, loads at full rate.
        for (int v = 0; v < 9; v++) begin
            for (int g = 0; g < vecs[v].groups; g++)
                group(vecs[v].w0, vecs[v].a0, vecs[v].w1, vecs[v].a1);
            for (int z = 0; z < vecs[v].zeros; z++)
                group(8'h00, 100, 8'h00, 100);
            push_const(vecs[v]);
            flush(vecs[v].shift, vecs[v].relu);
            drain();
        end

        // Mixed per-row weights with random operands.
        for (int g = 0; g < 4; g++)
            group(8'($urandom), int'($urandom_range(255)) - 128,
                  8'($urandom), int'($urandom_range(255)) - 128);
        push_model(2, 1'b0);
        flush(2, 1'b0);
        drain();

        // Backpressure 1,0,0,1.
        ready_mode = 1;
        base = n_xfer;
        group(8'b11_10_01_00, -7, 8'b00_01_10_01, 45);
        group(8'b11_10_01_00, -7, 8'b00_01_10_01, 45);
        push_model(0, 1'b0);
        flush(0, 1'b0);
        drain();
        check("backpressure_xfer_count", n_xfer - base, 16);
        ready_mode = 0;

        // Gapped load with a flush request held during the gap, then during drain.
        beat(8'h55, 10);
        check("gap_busy", int'(busy), 1);
        in_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("gap_flush_ready", int'(flush_ready), 0);
            tick();
        end
        in_flush = 1'b0;
        check("gap_no_output", int'(out_valid), 0);
        beat(8'hAA, 3);
        model_group(8'h55, 10, 8'hAA, 3);
        push_model(0, 1'b0);
        flush(0, 1'b0);
        in_flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_flush_ready", int'(flush_ready), 0);
            tick();
        end
        in_flush = 1'b0;
        drain();

        // Reset mid-drain at entry 5.
        group(8'h55, 10, 8'hAA, 3);
        push_model(0, 1'b0);
        flush(0, 1'b0);
        base = n_xfer;
        k = 0;
        while ((n_xfer - base) < 5 && k < 100) begin
            tick();
            k++;
        end
        check("mid_drain_xfers", n_xfer - base, 5);
        rst_n = 1'b0;
        #1;
        check("rst_drain_out_valid", int'(out_valid), 0);
        check("rst_drain_out_last",  int'(out_last), 0);
        check("rst_drain_busy",      int'(busy), 0);
        sb.delete();
        clear_model();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-group after beat0.
        beat(8'h55, 10);
        check("mid_group_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("rst_group_busy",      int'(busy), 0);
        check("rst_group_out_valid", int'(out_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_group_flush_ready", int'(flush_ready), 1);
        group(8'h55, 10, 8'hAA, 3);
        push_model(0, 1'b0);
        flush(0, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
